// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with majority-vote sampling and a small output FIFO.
// Frames carry parity/stop error flags through the FIFO; dropped frames set OVR.
module uart_rx_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic                      RX_IN,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_par_err,
  output logic                      rd_stp_err,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic                      OVR,
  input  logic                      ovr_clr,
  output logic                      busy
);

  localparam int PW = PRESCALE_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int EW = DATA_WIDTH + 2;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t state_q, state_d;
  logic          sync1_q, sync2_q, rx_s;
  logic [PW-1:0] edge_q, edge_d, p_q, p_d, p_in, half;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    smp_q, smp_d;
  logic [DW-1:0] data_q, data_d;
  logic          par_err_q, par_err_d, stp_err_q, stp_err_d;
  logic          pen_q, pen_d, ptyp_q, ptyp_d, stop2_q, stop2_d;
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [EW-1:0] entry, head;
  logic          ovr_q, ovr_d;
  logic          wrap, resolve, bit_v, last_data, last_stop;
  logic          push_req, push, pop, full, empty, drop;

  assign rx_s      = sync2_q;
  assign p_in      = (Prescale < PW'(4)) ? PW'(4) : Prescale;
  assign half      = p_q >> 1;
  assign wrap      = edge_q == p_q - PW'(1);
  assign resolve   = edge_q == half + PW'(1);
  assign bit_v     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) |
                     (smp_q[1] & rx_s);
  assign last_data = bit_q == 4'(DW - 1);
  assign last_stop = bit_q == {3'b000, stop2_q};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= S_IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      smp_q     <= '0;
      data_q    <= '0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      p_q       <= PW'(4);
      pen_q     <= 1'b0;
      ptyp_q    <= 1'b0;
      stop2_q   <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      mem_q     <= '{default: '0};
      ovr_q     <= 1'b0;
    end else begin
      sync1_q   <= RX_IN;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      smp_q     <= smp_d;
      data_q    <= data_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
      p_q       <= p_d;
      pen_q     <= pen_d;
      ptyp_q    <= ptyp_d;
      stop2_q   <= stop2_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      mem_q     <= mem_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!rx_s) state_d = S_START;
      S_START: begin
        if (resolve && bit_v) state_d = S_IDLE;
        else if (wrap)        state_d = S_DATA;
      end
      S_DATA:  if (wrap && last_data) state_d = pen_q ? S_PAR : S_STOP;
      S_PAR:   if (wrap) state_d = S_STOP;
      S_STOP:  if (resolve && last_stop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    edge_d    = wrap ? '0 : edge_q + PW'(1);
    bit_d     = bit_q;
    smp_d     = smp_q;
    data_d    = data_q;
    par_err_d = par_err_q;
    stp_err_d = stp_err_q;
    p_d       = p_q;
    pen_d     = pen_q;
    ptyp_d    = ptyp_q;
    stop2_d   = stop2_q;
    push_req  = 1'b0;
    entry     = {stp_err_q | ~bit_v, par_err_q, data_q};
    if (edge_q == half - PW'(1)) smp_d[0] = rx_s;
    if (edge_q == half)          smp_d[1] = rx_s;
    unique case (state_q)
      S_IDLE: begin
        // The detecting cycle is edge 0 of the start bit.
        edge_d    = rx_s ? '0 : PW'(1);
        bit_d     = '0;
        par_err_d = 1'b0;
        stp_err_d = 1'b0;
        if (!rx_s) begin
          p_d     = p_in;
          pen_d   = PAR_EN;
          ptyp_d  = PAR_TYP;
          stop2_d = STOP2;
        end
      end
      S_START: if (wrap) bit_d = '0;
      S_DATA: begin
        if (resolve) data_d = {bit_v, data_q[DW-1:1]};
        if (wrap)    bit_d = last_data ? '0 : bit_q + 4'd1;
      end
      S_PAR: if (resolve) par_err_d = ((^data_q) ^ bit_v) != ptyp_q;
      S_STOP: begin
        if (resolve) begin
          stp_err_d = stp_err_q | ~bit_v;
          push_req  = last_stop;
        end
        if (wrap) bit_d = bit_q + 4'd1;
      end
      default: ;
    endcase
    if (state_q != S_IDLE && state_d == S_IDLE) edge_d = '0;
  end

  always_comb begin
    empty = wr_q == rd_q;
    full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop   = !empty && rd_ready;
    // A same-cycle pop frees the slot the push lands in.
    push  = push_req && (!full || pop);
    drop  = push_req && full && !pop;
    wr_d  = wr_q + {{AW{1'b0}}, push};
    rd_d  = rd_q + {{AW{1'b0}}, pop};
    mem_d = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = entry;
    ovr_d = drop ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
  end

  always_comb begin
    head       = mem_q[rd_q[AW-1:0]];
    rd_valid   = !empty;
    rd_data    = rd_valid ? head[DW-1:0] : '0;
    rd_par_err = rd_valid & head[DW];
    rd_stp_err = rd_valid & head[DW+1];
    OVR        = ovr_q;
    busy       = state_q != S_IDLE;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: framing, parity, stop, glitch,
// majority vote, overrun, reset and back-to-back frames.
module tb_uart_rx_fifo;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic       RX_IN = 1'b1;
  logic [7:0] rd_data;
  logic       rd_par_err, rd_stp_err, rd_valid;
  logic       rd_ready = 1'b0;
  logic       OVR;
  logic       ovr_clr = 1'b0;
  logic       busy;

  int n_chk = 0;
  int n_bad = 0;
  int lat;

  uart_rx_fifo #(
    .DATA_WIDTH(8), .PRESCALE_WIDTH(6), .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK), .RST(RST), .Prescale(Prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .RX_IN(RX_IN), .rd_data(rd_data), .rd_par_err(rd_par_err),
    .rd_stp_err(rd_stp_err), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .OVR(OVR), .ovr_clr(ovr_clr),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One RX_IN value per clock; gbit/gedge flips a single cycle,
  // stop_at cuts the frame short after that many cycles.
  task automatic send(input logic [7:0] d, input bit pen,
                      input bit pbit, input bit s2, input bit s2v,
                      input int p, input int gbit, input int gedge,
                      input int stop_at);
    logic [15:0] fr;
    int n;
    fr = '1;
    n = 0;
    fr[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin fr[n] = d[i]; n++; end
    if (pen) begin fr[n] = pbit; n++; end
    fr[n] = 1'b1; n++;
    if (s2) begin fr[n] = s2v; n++; end
    for (int b = 0; b < n; b++) begin
      for (int e = 0; e < p; e++) begin
        if (b * p + e == stop_at) return;
        RX_IN = fr[b] ^ ((b == gbit) && (e == gedge));
        @(negedge CLK);
      end
    end
    RX_IN = 1'b1;
  endtask

  task automatic send8(input logic [7:0] d);
    send(d, 1'b0, 1'b0, 1'b0, 1'b1, 8, -1, -1, -1);
  endtask

  task automatic pop();
    rd_ready = 1'b1;
    @(negedge CLK);
    rd_ready = 1'b0;
  endtask

  initial begin
    idle(3);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_ovr", OVR, 0);
    check("rst_busy", busy, 0);
    RST = 1'b0;
    idle(3);
    check("idle_perr", rd_par_err, 0);
    check("idle_serr", rd_stp_err, 0);

    // 8N1 0xA5 at P=8: 2 synchroniser cycles + 78 to rd_valid.
    lat = 0;
    fork
      send8(8'hA5);
      begin
        while (!rd_valid && lat < 200) begin
          @(negedge CLK);
          lat++;
        end
      end
    join
    check("lat", lat, 80);
    idle(4);
    check("a5_data", rd_data, 8'hA5);
    check("a5_perr", rd_par_err, 0);
    check("a5_serr", rd_stp_err, 0);
    pop();
    check("a5_empty", rd_valid, 0);

    // Even parity, data 0x03, parity bit 1: error.
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    send(8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 8, -1, -1, -1);
    idle(4);
    check("pe_data", rd_data, 8'h03);
    check("pe_perr", rd_par_err, 1);
    check("pe_serr", rd_stp_err, 0);
    pop();
    PAR_TYP = 1'b1;
    send(8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 8, -1, -1, -1);
    idle(4);
    check("po_data", rd_data, 8'h03);
    check("po_perr", rd_par_err, 0);
    pop();
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;

    // Two stop bits, second low.
    STOP2 = 1'b1;
    send(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8, -1, -1, -1);
    idle(20);
    check("s2_data", rd_data, 8'h3C);
    check("s2_serr", rd_stp_err, 1);
    check("s2_perr", rd_par_err, 0);
    pop();
    check("s2_single", rd_valid, 0);
    check("s2_busy", busy, 0);
    STOP2 = 1'b0;

    // Two-cycle low glitch.
    RX_IN = 1'b0;
    idle(2);
    RX_IN = 1'b1;
    idle(1);
    check("gl_busy_hi", busy, 1);
    idle(20);
    check("gl_busy_lo", busy, 0);
    check("gl_nopush", rd_valid, 0);

    // P=16, middle sample of data bit 1 inverted.
    Prescale = 6'd16;
    send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 16, 2, 8, -1);
    idle(4);
    check("mv_data", rd_data, 8'h5A);
    pop();
    Prescale = 6'd8;

    // Overrun: five frames into a 4-entry FIFO.
    for (int i = 1; i <= 5; i++) send8(8'(i));
    idle(4);
    check("ov_flag", OVR, 1);
    for (int i = 1; i <= 4; i++) begin
      check("ov_valid", rd_valid, 1);
      check("ov_data", rd_data, i);
      pop();
    end
    check("ov_empty", rd_valid, 0);
    check("ov_sticky", OVR, 1);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    check("ov_clr", OVR, 0);

    // Reset in the middle of DATA with one entry queued.
    send8(8'h11);
    idle(2);
    send(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 8, -1, -1, 30);
    check("mr_busy", busy, 1);
    check("mr_valid", rd_valid, 1);
    RX_IN = 1'b1;
    RST = 1'b1;
    idle(2);
    check("mr_rvalid", rd_valid, 0);
    check("mr_rdata", rd_data, 0);
    check("mr_rbusy", busy, 0);
    RST = 1'b0;
    idle(20);
    check("mr_empty", rd_valid, 0);
    check("mr_idle", busy, 0);

    // Back-to-back frames, no idle gap.
    send8(8'hFF);
    send8(8'h00);
    idle(4);
    check("bb_first", rd_data, 8'hFF);
    check("bb_v1", rd_valid, 1);
    pop();
    check("bb_second", rd_data, 8'h00);
    check("bb_v2", rd_valid, 1);
    check("bb_serr", rd_stp_err, 0);
    pop();
    check("bb_empty", rd_valid, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised next-generation UART receiver: oversampled serial input, majority-vote bit sampling, configurable data width, optional parity, one or two stop bits and an output FIFO with valid/ready pop handshake. Sits between the pad-side RX_IN line and the system bus/consumer. It replaces the single-register receiver, which has no buffering and no overrun reporting.

## Interface
- DATA_WIDTH, 8: data bits per frame, legal 5..9.
- PRESCALE_WIDTH, 6: width of Prescale.
- FIFO_DEPTH, 4: FIFO entries, power of 2, ≥2.

- CLK  input  1  oversampling clock.
- RST  input  1  reset, asynchronous, active-high.
- Prescale  input  PRESCALE_WIDTH  clocks per bit (P). Values <4 are treated as 4.
- PAR_EN  input  1  1 = parity bit present.
- PAR_TYP  input  1  0 = even, 1 = odd.
- STOP2  input  1  1 = two stop bits.
- RX_IN  input  1  serial line, idle high, asynchronous.
- rd_data  output  DATA_WIDTH  head-of-FIFO data, all zeros when rd_valid=0.
- rd_par_err  output  1  head entry parity error, 0 when rd_valid=0.
- rd_stp_err  output  1  head entry stop error, 0 when rd_valid=0.
- rd_valid  output  1  FIFO non-empty.
- rd_ready  input  1  pop request.
- OVR  output  1  sticky overrun flag.
- ovr_clr  input  1  clears OVR.
- busy  output  1  frame in progress (state ≠ IDLE).

## Operation
- RX_IN passes through a 2-flop synchroniser (reset value 1) to give rx_s. All logic uses rx_s.
- Config latch: on leaving IDLE, P, PAR_EN, PAR_TYP and STOP2 are latched. Input changes mid-frame take effect at the next frame.
- Edge counter runs 0..P-1 per bit and wraps. A bit counter advances on wrap.
- Sampling: rx_s captured at edge_cnt = P/2-1, P/2, P/2+1 (P/2 floored). The bit value is the majority of the 3 samples, resolved at edge_cnt = P/2+1.
- FSM states:
  - IDLE: when rx_s=0, that cycle is edge 0 of START.
  - START: if the resolved bit is 1, this is a glitch. Go to IDLE, nothing pushed. Otherwise go to DATA at wrap.
  - DATA: DATA_WIDTH bits, LSB first, shifted into a register. After the last bit go to PARITY if PAR_EN, else STOP.
  - PARITY: par_err = (XOR of data bits ^ parity bit) != PAR_TYP.
  - STOP: 1 or 2 bits (STOP2). stp_err = 1 if any resolved stop bit is 0.
    - On the cycle the final stop bit resolves, push {stp_err, par_err, data}; next state is IDLE.
    - The remaining half-bit is not waited for, so a back-to-back start bit is caught.
- FIFO push/pop:
  - Push when not full.
  - Full and no pop: frame dropped and OVR set. Full with a same-cycle pop: push accepted, no overrun.
  - Pop on rd_valid & rd_ready. rd_ready with FIFO empty is ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits, wrap naturally. full = MSBs differ and LSBs equal.
- OVR:
  - Set by a dropped frame, cleared by ovr_clr.
  - Set and clear in the same cycle: set wins.
- Errored frames (parity or stop) are still pushed, with their flags.

## Timing
- Reset values: rd_valid 0, rd_data 0, rd_par_err 0, rd_stp_err 0, OVR 0, busy 0. FSM goes to IDLE, counters and FIFO pointers to 0.
- Reset mid-frame aborts the frame and empties the FIFO.
- rx_s lags RX_IN by 2 cycles.
- Frame length F = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2 bits.
- Push cycle = (F-1)·P + P/2+1 cycles after the first cycle with rx_s=0. rd_valid rises on the following cycle.
- Pop takes effect on the clock edge. The next entry (or empty) is visible the cycle after.
- busy is high from the cycle after start detection through the push cycle.
- Throughput: one pop per cycle. A push and a pop in the same cycle leave the FIFO count unchanged.

## Test plan
- Basic frame: P=8, 8N1, byte 0xA5. rd_valid rises 78 cycles after rx_s first falls; rd_data=0xA5, both error flags 0.
- Parity: PAR_EN=1, PAR_TYP=0, byte 0x03 with parity bit 1. rd_par_err=1. Repeat with PAR_TYP=1 and same bits: rd_par_err=0.
- Stop and glitch:
  - STOP2=1, second stop bit driven 0 → rd_stp_err=1, data intact.
  - 2-cycle low pulse on RX_IN → no push, busy returns to 0.
- Majority vote: P=16, middle sample inverted on one data bit of 0x5A → rd_data=0x5A.
- Overrun: FIFO_DEPTH=4, rd_ready=0, send 5 frames 0x01..0x05.
  - OVR=1 and FIFO holds 0x01..0x04.
  - Pop all → 0x01..0x04 in order, rd_valid falls.
  - ovr_clr → OVR=0.
- Reset and back-to-back:
  - RST asserted mid-DATA → all outputs 0 and FIFO empty.
  - Then two back-to-back 8N1 frames (no idle gap), 0xFF and 0x00 → both received in order.
